id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Dual-issue ID/EX pipeline stage directly downstream of the decode-hazard/forwarding logic. Each cycle it registers the two decoded issue slots and their forwarded operands into the IDEX registers that feed execute. It inserts bubbles on load-use stalls and squashes on execute-stage flushes. It also splits a bundle into two single-issue cycles when slot 1 depends on slot 0 or both slots are memory operations. Its registered `IDEX_RdAddr_k`, `IDEX_WbRdEn_k` and `IDEX_LdType_k` outputs close the forwarding loop back into the hazard logic.

## Interface
Parameters:
- `DATA_WIDTH`, 32, operand/PC/immediate width
- `RF_ADDR_WIDTH`, 5, register address width
- `LD_TYPE_WIDTH`, 3, load type code width (`LD_XXX` = no load)
- `ST_TYPE_WIDTH`, 2, store type code width (`ST_XXX` = no store)
- `ALU_OP_WIDTH`, 5, ALU opcode width

Ports (k = 0,1; one set per slot):
- `clk`  in  1  single clock; all state updates on its rising edge
- `rst`  in  1  reset; synchronous, active-high
- `Decode_Valid_k`  in  1  slot k holds a real instruction
- `Decode_Pc_k`  in  DATA_WIDTH  slot PC
- `Decode_Rs1Addr_k`, `Decode_Rs2Addr_k`  in  RF_ADDR_WIDTH  source registers
- `Decode_RdAddr_k`  in  RF_ADDR_WIDTH  destination register
- `Decode_WbRdEn_k`  in  1  slot writes rd
- `Decode_LdType_k`  in  LD_TYPE_WIDTH  load type
- `Decode_StType_k`  in  ST_TYPE_WIDTH  store type
- `Decode_AluOp_k`  in  ALU_OP_WIDTH  ALU operation
- `Decode_Imm_k`  in  DATA_WIDTH  immediate
- `DecodeHazard_Rs1Data_k`, `DecodeHazard_Rs2Data_k`  in  DATA_WIDTH  forwarded operands
- `DecodeHazard_StallReq`  in  1  load-use stall request
- `Ex_StallReq`  in  1  execute/memory backpressure; freeze the stage
- `Ex_Flush`  in  1  redirect from execute; squash the stage
- `IDEX_Valid_k`, `IDEX_Pc_k`, `IDEX_RdAddr_k`, `IDEX_WbRdEn_k`, `IDEX_LdType_k`, `IDEX_StType_k`, `IDEX_AluOp_k`, `IDEX_Imm_k`, `IDEX_Rs1Data_k`, `IDEX_Rs2Data_k`  out  (widths as the inputs)  registered slot k
- `IdEx_HoldIfId`  out  1  combinational; hold the IF/ID register and PC this cycle
- `IdEx_BubbleCnt`  out  32  bubble cycles inserted; wraps

## Operation
- **Memory op:** a slot is a memory op when `LdType != LD_XXX` or `StType != ST_XXX`.
- **Pair hazard** (`pairHaz`) is true when `Decode_Valid_0 && Decode_Valid_1` and either:
  - (`Decode_WbRdEn_0`, `RdAddr_0 != 0`, and `RdAddr_0` equals `Rs1Addr_1` or `Rs2Addr_1`), or
  - both slots are memory ops.
- **Bubble:** `Valid`=0, `WbRdEn`=0, `LdType=LD_XXX`, `StType=ST_XXX`, and all other fields 0.
- **FSM states:** NORMAL and SPLIT. Per-cycle priority, highest first:
  1. `Ex_Flush`: both slots bubble, state goes to NORMAL, hold=0.
  2. `Ex_StallReq`: all IDEX registers and state hold, hold=1, counter unchanged.
  3. `DecodeHazard_StallReq`: both slots bubble, state unchanged, hold=1, counter +1.
  4. NORMAL with `pairHaz`: slot 0 loads from decode, slot 1 bubbles, state goes to SPLIT, hold=1, counter +1.
  5. NORMAL otherwise: both slots load from decode, hold=0.
  6. SPLIT: slot 0 bubbles, slot 1 loads the live decode slot-1 inputs (re-forwarded by the hazard logic), state goes to NORMAL, hold=0, counter +1.
- **Invalid decode slot:** loads as a bubble; it never triggers `pairHaz`.
- **Counter:** counts the cycles in which a bubble was forced into at least one slot by rules 3, 4 or 6. Flush bubbles are not counted.

## Timing
- **Reset:** all `IDEX_*` outputs take the bubble value, state is NORMAL, and `IdEx_BubbleCnt` is 0. Reset has priority over all inputs.
- **Latency:** one cycle from decode inputs to `IDEX_*`.
- **Hold:** `IdEx_HoldIfId` depends only on the current inputs and state (no register). It is 0 during reset.
- **Split cost:** a split bundle takes exactly 2 issue cycles (3 or more if load-use stalls intervene).
- **Simultaneous flush and stall:** flush wins.
- **Flush in SPLIT:** the pending slot 1 is dropped.

## Structure
- `LD_XXX`, `ST_XXX`, the width macros and the FSM state encoding belong in the shared define header.
- Natural sub-module: `id_ex_slot_reg`, a single-slot register with load, hold and bubble controls, instantiated twice. The FSM and counter live in the top level.

## Test plan
- **Independent pair:** reset, then an independent valid pair (add x1; add x2) → both `IDEX_Valid`=1 after 1 cycle, hold=0, counter=0.
- **Dependent pair:** slot 0 `add x5`, slot 1 reads x5 → cycle 1: `IDEX_Valid_0`=1, `IDEX_Valid_1`=0, hold=1. Cycle 2: `IDEX_Valid_1`=1, `IDEX_Valid_0`=0. Counter=2.
- **Two memory ops:** lw + sw pair → split identical to the dependent-pair case.
- **Load-use stall:** `DecodeHazard_StallReq`=1 for one cycle → both bubbles, `IDEX_LdType_k=LD_XXX`, hold=1, counter +1.
- **Flush in SPLIT:** `Ex_Flush` in SPLIT with `Ex_StallReq`=1 → bubbles, state NORMAL, hold=0. The next pair issues dual.
- **Backend stall:** `Ex_StallReq` held for 3 cycles → IDEX outputs unchanged, hold=1 throughout. Assert `rst` mid-stall → bubble outputs and counter 0 on the next edge.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared widths, no-op load/store codes and ID/EX FSM encoding
package id_ex_stage_pkg;
  localparam int DATA_W   = 32;
  localparam int RF_ADDR_W = 5;
  localparam int LD_TYPE_W = 3;
  localparam int ST_TYPE_W = 2;
  localparam int ALU_OP_W  = 5;

  localparam int LD_XXX = 0;
  localparam int ST_XXX = 0;

  typedef enum logic {
    S_NORMAL = 1'b0,
    S_SPLIT  = 1'b1
  } idExState_e;
endpackage

// File: rtl/id_ex_slot_reg.sv
// rtl/id_ex_slot_reg.sv - one ID/EX issue-slot register with load, hold and bubble controls
import id_ex_stage_pkg::*;

module id_ex_slot_reg #(
  parameter int DATA_WIDTH    = DATA_W,
  parameter int RF_ADDR_WIDTH = RF_ADDR_W,
  parameter int LD_TYPE_WIDTH = LD_TYPE_W,
  parameter int ST_TYPE_WIDTH = ST_TYPE_W,
  parameter int ALU_OP_WIDTH  = ALU_OP_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     bubble,
  input  logic                     dValid,
  input  logic [DATA_WIDTH-1:0]    dPc,
  input  logic [RF_ADDR_WIDTH-1:0] dRdAddr,
  input  logic                     dWbRdEn,
  input  logic [LD_TYPE_WIDTH-1:0] dLdType,
  input  logic [ST_TYPE_WIDTH-1:0] dStType,
  input  logic [ALU_OP_WIDTH-1:0]  dAluOp,
  input  logic [DATA_WIDTH-1:0]    dImm,
  input  logic [DATA_WIDTH-1:0]    dRs1Data,
  input  logic [DATA_WIDTH-1:0]    dRs2Data,
  output logic                     qValid,
  output logic [DATA_WIDTH-1:0]    qPc,
  output logic [RF_ADDR_WIDTH-1:0] qRdAddr,
  output logic                     qWbRdEn,
  output logic [LD_TYPE_WIDTH-1:0] qLdType,
  output logic [ST_TYPE_WIDTH-1:0] qStType,
  output logic [ALU_OP_WIDTH-1:0]  qAluOp,
  output logic [DATA_WIDTH-1:0]    qImm,
  output logic [DATA_WIDTH-1:0]    qRs1Data,
  output logic [DATA_WIDTH-1:0]    qRs2Data
);
  // An invalid decode slot is loaded as a bubble so stale fields never reach execute.
  always_ff @(posedge clk) begin
    if (rst || bubble || (load && !dValid)) begin
      qValid   <= 1'b0;
      qPc      <= '0;
      qRdAddr  <= '0;
      qWbRdEn  <= 1'b0;
      qLdType  <= LD_TYPE_WIDTH'(LD_XXX);
      qStType  <= ST_TYPE_WIDTH'(ST_XXX);
      qAluOp   <= '0;
      qImm     <= '0;
      qRs1Data <= '0;
      qRs2Data <= '0;
    end else if (load) begin
      qValid   <= 1'b1;
      qPc      <= dPc;
      qRdAddr  <= dRdAddr;
      qWbRdEn  <= dWbRdEn;
      qLdType  <= dLdType;
      qStType  <= dStType;
      qAluOp   <= dAluOp;
      qImm     <= dImm;
      qRs1Data <= dRs1Data;
      qRs2Data <= dRs2Data;
    end
  end
endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - dual-issue ID/EX stage with stall bubbles, flush squash and bundle split
import id_ex_stage_pkg::*;

module id_ex_stage #(
  parameter int DATA_WIDTH    = DATA_W,
  parameter int RF_ADDR_WIDTH = RF_ADDR_W,
  parameter int LD_TYPE_WIDTH = LD_TYPE_W,
  parameter int ST_TYPE_WIDTH = ST_TYPE_W,
  parameter int ALU_OP_WIDTH  = ALU_OP_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     Decode_Valid_0,
  input  logic [DATA_WIDTH-1:0]    Decode_Pc_0,
  input  logic [RF_ADDR_WIDTH-1:0] Decode_Rs1Addr_0,
  input  logic [RF_ADDR_WIDTH-1:0] Decode_Rs2Addr_0,
  input  logic [RF_ADDR_WIDTH-1:0] Decode_RdAddr_0,
  input  logic                     Decode_WbRdEn_0,
  input  logic [LD_TYPE_WIDTH-1:0] Decode_LdType_0,
  input  logic [ST_TYPE_WIDTH-1:0] Decode_StType_0,
  input  logic [ALU_OP_WIDTH-1:0]  Decode_AluOp_0,
  input  logic [DATA_WIDTH-1:0]    Decode_Imm_0,
  input  logic [DATA_WIDTH-1:0]    DecodeHazard_Rs1Data_0,
  input  logic [DATA_WIDTH-1:0]    DecodeHazard_Rs2Data_0,
  input  logic                     Decode_Valid_1,
  input  logic [DATA_WIDTH-1:0]    Decode_Pc_1,
  input  logic [RF_ADDR_WIDTH-1:0] Decode_Rs1Addr_1,
  input  logic [RF_ADDR_WIDTH-1:0] Decode_Rs2Addr_1,
  input  logic [RF_ADDR_WIDTH-1:0] Decode_RdAddr_1,
  input  logic                     Decode_WbRdEn_1,
  input  logic [LD_TYPE_WIDTH-1:0] Decode_LdType_1,
  input  logic [ST_TYPE_WIDTH-1:0] Decode_StType_1,
  input  logic [ALU_OP_WIDTH-1:0]  Decode_AluOp_1,
  input  logic [DATA_WIDTH-1:0]    Decode_Imm_1,
  input  logic [DATA_WIDTH-1:0]    DecodeHazard_Rs1Data_1,
  input  logic [DATA_WIDTH-1:0]    DecodeHazard_Rs2Data_1,
  input  logic                     DecodeHazard_StallReq,
  input  logic                     Ex_StallReq,
  input  logic                     Ex_Flush,
  output logic                     IDEX_Valid_0,
  output logic [DATA_WIDTH-1:0]    IDEX_Pc_0,
  output logic [RF_ADDR_WIDTH-1:0] IDEX_RdAddr_0,
  output logic                     IDEX_WbRdEn_0,
  output logic [LD_TYPE_WIDTH-1:0] IDEX_LdType_0,
  output logic [ST_TYPE_WIDTH-1:0] IDEX_StType_0,
  output logic [ALU_OP_WIDTH-1:0]  IDEX_AluOp_0,
  output logic [DATA_WIDTH-1:0]    IDEX_Imm_0,
  output logic [DATA_WIDTH-1:0]    IDEX_Rs1Data_0,
  output logic [DATA_WIDTH-1:0]    IDEX_Rs2Data_0,
  output logic                     IDEX_Valid_1,
  output logic [DATA_WIDTH-1:0]    IDEX_Pc_1,
  output logic [RF_ADDR_WIDTH-1:0] IDEX_RdAddr_1,
  output logic                     IDEX_WbRdEn_1,
  output logic [LD_TYPE_WIDTH-1:0] IDEX_LdType_1,
  output logic [ST_TYPE_WIDTH-1:0] IDEX_StType_1,
  output logic [ALU_OP_WIDTH-1:0]  IDEX_AluOp_1,
  output logic [DATA_WIDTH-1:0]    IDEX_Imm_1,
  output logic [DATA_WIDTH-1:0]    IDEX_Rs1Data_1,
  output logic [DATA_WIDTH-1:0]    IDEX_Rs2Data_1,
  output logic                     IdEx_HoldIfId,
  output logic [31:0]              IdEx_BubbleCnt
);
  idExState_e state, nextState;
  logic load0, load1, bubble0, bubble1, holdIfId, cntInc;
  logic isMem0, isMem1, rawDep, pairHaz;
  logic unusedSlot0Rs;

  // Slot 0 source registers only matter to the upstream hazard logic.
  assign unusedSlot0Rs = ^{Decode_Rs1Addr_0, Decode_Rs2Addr_0};

  assign isMem0 = (Decode_LdType_0 != LD_TYPE_WIDTH'(LD_XXX)) || (Decode_StType_0 != ST_TYPE_WIDTH'(ST_XXX));
  assign isMem1 = (Decode_LdType_1 != LD_TYPE_WIDTH'(LD_XXX)) || (Decode_StType_1 != ST_TYPE_WIDTH'(ST_XXX));
  assign rawDep = Decode_WbRdEn_0 && (Decode_RdAddr_0 != '0) &&
                  ((Decode_RdAddr_0 == Decode_Rs1Addr_1) || (Decode_RdAddr_0 == Decode_Rs2Addr_1));
  assign pairHaz = Decode_Valid_0 && Decode_Valid_1 && (rawDep || (isMem0 && isMem1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_NORMAL;
      IdEx_BubbleCnt <= '0;
    end else begin
      state <= nextState;
      if (cntInc) IdEx_BubbleCnt <= IdEx_BubbleCnt + 32'd1;
    end
  end

  always_comb begin
    nextState = state;
    load0     = 1'b0;
    load1     = 1'b0;
    bubble0   = 1'b0;
    bubble1   = 1'b0;
    holdIfId  = 1'b0;
    cntInc    = 1'b0;
    if (rst) begin
      nextState = S_NORMAL;
    end else if (Ex_Flush) begin
      bubble0   = 1'b1;
      bubble1   = 1'b1;
      nextState = S_NORMAL;
    end else if (Ex_StallReq) begin
      holdIfId = 1'b1;
    end else if (DecodeHazard_StallReq) begin
      bubble0  = 1'b1;
      bubble1  = 1'b1;
      holdIfId = 1'b1;
      cntInc   = 1'b1;
    end else if (state == S_NORMAL) begin
      load0 = 1'b1;
      if (pairHaz) begin
        bubble1   = 1'b1;
        holdIfId  = 1'b1;
        cntInc    = 1'b1;
        nextState = S_SPLIT;
      end else begin
        load1 = 1'b1;
      end
    end else begin
      // Second half of a split: slot 1 takes the freshly re-forwarded decode operands.
      bubble0   = 1'b1;
      load1     = 1'b1;
      cntInc    = 1'b1;
      nextState = S_NORMAL;
    end
  end

  assign IdEx_HoldIfId = holdIfId;

  id_ex_slot_reg #(
    .DATA_WIDTH(DATA_WIDTH), .RF_ADDR_WIDTH(RF_ADDR_WIDTH), .LD_TYPE_WIDTH(LD_TYPE_WIDTH),
    .ST_TYPE_WIDTH(ST_TYPE_WIDTH), .ALU_OP_WIDTH(ALU_OP_WIDTH)
  ) slot0 (
    .clk(clk), .rst(rst), .load(load0), .bubble(bubble0),
    .dValid(Decode_Valid_0), .dPc(Decode_Pc_0), .dRdAddr(Decode_RdAddr_0), .dWbRdEn(Decode_WbRdEn_0),
    .dLdType(Decode_LdType_0), .dStType(Decode_StType_0), .dAluOp(Decode_AluOp_0), .dImm(Decode_Imm_0),
    .dRs1Data(DecodeHazard_Rs1Data_0), .dRs2Data(DecodeHazard_Rs2Data_0),
    .qValid(IDEX_Valid_0), .qPc(IDEX_Pc_0), .qRdAddr(IDEX_RdAddr_0), .qWbRdEn(IDEX_WbRdEn_0),
    .qLdType(IDEX_LdType_0), .qStType(IDEX_StType_0), .qAluOp(IDEX_AluOp_0), .qImm(IDEX_Imm_0),
    .qRs1Data(IDEX_Rs1Data_0), .qRs2Data(IDEX_Rs2Data_0)
  );

  id_ex_slot_reg #(
    .DATA_WIDTH(DATA_WIDTH), .RF_ADDR_WIDTH(RF_ADDR_WIDTH), .LD_TYPE_WIDTH(LD_TYPE_WIDTH),
    .ST_TYPE_WIDTH(ST_TYPE_WIDTH), .ALU_OP_WIDTH(ALU_OP_WIDTH)
  ) slot1 (
    .clk(clk), .rst(rst), .load(load1), .bubble(bubble1),
    .dValid(Decode_Valid_1), .dPc(Decode_Pc_1), .dRdAddr(Decode_RdAddr_1), .dWbRdEn(Decode_WbRdEn_1),
    .dLdType(Decode_LdType_1), .dStType(Decode_StType_1), .dAluOp(Decode_AluOp_1), .dImm(Decode_Imm_1),
    .dRs1Data(DecodeHazard_Rs1Data_1), .dRs2Data(DecodeHazard_Rs2Data_1),
    .qValid(IDEX_Valid_1), .qPc(IDEX_Pc_1), .qRdAddr(IDEX_RdAddr_1), .qWbRdEn(IDEX_WbRdEn_1),
    .qLdType(IDEX_LdType_1), .qStType(IDEX_StType_1), .qAluOp(IDEX_AluOp_1), .qImm(IDEX_Imm_1),
    .qRs1Data(IDEX_Rs1Data_1), .qRs2Data(IDEX_Rs2Data_1)
  );
endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed and randomized checks of id_ex_stage against a slot-level model
module tb_id_ex_stage;
  localparam int SW = 145;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        wb;
    logic [2:0]  ld;
    logic [1:0]  st;
    logic [4:0]  alu;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } slot_t;

  localparam slot_t BUBBLE = '0;

  logic clk, rst;
  logic        dValid[2];
  logic [31:0] dPc[2];
  logic [4:0]  dRs1a[2];
  logic [4:0]  dRs2a[2];
  logic [4:0]  dRd[2];
  logic        dWb[2];
  logic [2:0]  dLd[2];
  logic [1:0]  dSt[2];
  logic [4:0]  dAlu[2];
  logic [31:0] dImm[2];
  logic [31:0] dR1[2];
  logic [31:0] dR2[2];
  logic dhStall, exStall, flush;

  logic        qValid[2];
  logic [31:0] qPc[2];
  logic [4:0]  qRd[2];
  logic        qWb[2];
  logic [2:0]  qLd[2];
  logic [1:0]  qSt[2];
  logic [4:0]  qAlu[2];
  logic [31:0] qImm[2];
  logic [31:0] qR1[2];
  logic [31:0] qR2[2];
  logic        hold;
  logic [31:0] cnt;

  slot_t       exp[2];
  logic [31:0] expCnt;
  bit          splitPending;
  int          vectors = 0, miscompares = 0, nChecks = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst),
    .Decode_Valid_0(dValid[0]), .Decode_Pc_0(dPc[0]), .Decode_Rs1Addr_0(dRs1a[0]), .Decode_Rs2Addr_0(dRs2a[0]),
    .Decode_RdAddr_0(dRd[0]), .Decode_WbRdEn_0(dWb[0]), .Decode_LdType_0(dLd[0]), .Decode_StType_0(dSt[0]),
    .Decode_AluOp_0(dAlu[0]), .Decode_Imm_0(dImm[0]), .DecodeHazard_Rs1Data_0(dR1[0]), .DecodeHazard_Rs2Data_0(dR2[0]),
    .Decode_Valid_1(dValid[1]), .Decode_Pc_1(dPc[1]), .Decode_Rs1Addr_1(dRs1a[1]), .Decode_Rs2Addr_1(dRs2a[1]),
    .Decode_RdAddr_1(dRd[1]), .Decode_WbRdEn_1(dWb[1]), .Decode_LdType_1(dLd[1]), .Decode_StType_1(dSt[1]),
    .Decode_AluOp_1(dAlu[1]), .Decode_Imm_1(dImm[1]), .DecodeHazard_Rs1Data_1(dR1[1]), .DecodeHazard_Rs2Data_1(dR2[1]),
    .DecodeHazard_StallReq(dhStall), .Ex_StallReq(exStall), .Ex_Flush(flush),
    .IDEX_Valid_0(qValid[0]), .IDEX_Pc_0(qPc[0]), .IDEX_RdAddr_0(qRd[0]), .IDEX_WbRdEn_0(qWb[0]),
    .IDEX_LdType_0(qLd[0]), .IDEX_StType_0(qSt[0]), .IDEX_AluOp_0(qAlu[0]), .IDEX_Imm_0(qImm[0]),
    .IDEX_Rs1Data_0(qR1[0]), .IDEX_Rs2Data_0(qR2[0]),
    .IDEX_Valid_1(qValid[1]), .IDEX_Pc_1(qPc[1]), .IDEX_RdAddr_1(qRd[1]), .IDEX_WbRdEn_1(qWb[1]),
    .IDEX_LdType_1(qLd[1]), .IDEX_StType_1(qSt[1]), .IDEX_AluOp_1(qAlu[1]), .IDEX_Imm_1(qImm[1]),
    .IDEX_Rs1Data_1(qR1[1]), .IDEX_Rs2Data_1(qR2[1]),
    .IdEx_HoldIfId(hold), .IdEx_BubbleCnt(cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic slot_t fromDecode(int k);
    if (!dValid[k]) return BUBBLE;
    return '{1'b1, dPc[k], dRd[k], dWb[k], dLd[k], dSt[k], dAlu[k], dImm[k], dR1[k], dR2[k]};
  endfunction

  function automatic slot_t observed(int k);
    return '{qValid[k], qPc[k], qRd[k], qWb[k], qLd[k], qSt[k], qAlu[k], qImm[k], qR1[k], qR2[k]};
  endfunction

  // Bundle must be split if slot 1 consumes slot 0's result or both touch memory.
  function automatic bit mustSplit();
    bit reads, mem0, mem1;
    reads = dWb[0] && dRd[0] != 0 && (dRd[0] == dRs1a[1] || dRd[0] == dRs2a[1]);
    mem0  = dLd[0] != 0 || dSt[0] != 0;
    mem1  = dLd[1] != 0 || dSt[1] != 0;
    return dValid[0] && dValid[1] && (reads || (mem0 && mem1));
  endfunction

  task automatic chk(string tag, logic [SW-1:0] obs, logic [SW-1:0] expv);
    nChecks++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step(string tag);
    slot_t n0, n1;
    logic [31:0] nCnt;
    bit nSplit, eHold;
    #1;
    n0 = exp[0]; n1 = exp[1]; nCnt = expCnt; nSplit = splitPending; eHold = 1'b0;
    if (rst) begin
      n0 = BUBBLE; n1 = BUBBLE; nCnt = 0; nSplit = 0;
    end else if (flush) begin
      n0 = BUBBLE; n1 = BUBBLE; nSplit = 0;
    end else if (exStall) begin
      eHold = 1'b1;
    end else if (dhStall) begin
      n0 = BUBBLE; n1 = BUBBLE; eHold = 1'b1; nCnt = expCnt + 1;
    end else if (splitPending) begin
      n0 = BUBBLE; n1 = fromDecode(1); nSplit = 0; nCnt = expCnt + 1;
    end else if (mustSplit()) begin
      n0 = fromDecode(0); n1 = BUBBLE; nSplit = 1; eHold = 1'b1; nCnt = expCnt + 1;
    end else begin
      n0 = fromDecode(0); n1 = fromDecode(1);
    end
    chk({tag, "/hold"}, SW'(hold), SW'(eHold));
    @(posedge clk);
    #1;
    exp[0] = n0; exp[1] = n1; expCnt = nCnt; splitPending = nSplit;
    vectors++;
    chk({tag, "/slot0"}, observed(0), exp[0]);
    chk({tag, "/slot1"}, observed(1), exp[1]);
    chk({tag, "/cnt"}, SW'(cnt), SW'(expCnt));
  endtask

  task automatic setInsn(int k, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2, logic wb, logic [2:0] ld, logic [1:0] st);
    dValid[k] = 1'b1; dPc[k] = $urandom; dRd[k] = rd; dRs1a[k] = rs1; dRs2a[k] = rs2; dWb[k] = wb;
    dLd[k] = ld; dSt[k] = st; dAlu[k] = 5'($urandom); dImm[k] = $urandom; dR1[k] = $urandom; dR2[k] = $urandom;
  endtask

  task automatic rndSlots();
    for (int k = 0; k < 2; k++) begin
      setInsn(k, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom),
              ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0,
              ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0);
      dValid[k] = $urandom_range(0, 7) != 0;
    end
  endtask

  task automatic indepPair();
    setInsn(0, 5'd1, 5'd3, 5'd4, 1'b1, 3'd0, 2'd0);
    setInsn(1, 5'd2, 5'd6, 5'd7, 1'b1, 3'd0, 2'd0);
  endtask

  initial begin
    exp[0] = BUBBLE; exp[1] = BUBBLE; expCnt = 0; splitPending = 0;
    dhStall = 0; exStall = 0; flush = 0;
    rst = 1'b1;
    rndSlots();
    step("reset");
    rst = 1'b0;

    indepPair();
    step("indep");

    setInsn(0, 5'd5, 5'd1, 5'd2, 1'b1, 3'd0, 2'd0);
    setInsn(1, 5'd6, 5'd5, 5'd3, 1'b1, 3'd0, 2'd0);
    step("dep_c1");
    step("dep_c2");

    setInsn(0, 5'd8, 5'd1, 5'd0, 1'b1, 3'd2, 2'd0);
    setInsn(1, 5'd0, 5'd9, 5'd10, 1'b0, 3'd0, 2'd2);
    step("mem_c1");
    step("mem_c2");

    indepPair();
    dhStall = 1'b1;
    step("loaduse");
    dhStall = 1'b0;
    step("loaduse_after");

    setInsn(0, 5'd5, 5'd1, 5'd2, 1'b1, 3'd0, 2'd0);
    setInsn(1, 5'd6, 5'd0, 5'd5, 1'b1, 3'd0, 2'd0);
    step("split_enter");
    exStall = 1'b1; flush = 1'b1;
    step("flush_split");
    exStall = 1'b0; flush = 1'b0;
    indepPair();
    step("post_flush_dual");

    indepPair();
    step("pre_stall");
    exStall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rndSlots();
      step("backend_stall");
    end
    rst = 1'b1;
    step("reset_mid_stall");
    rst = 1'b0; exStall = 1'b0;

    for (int i = 0; i < 400; i++) begin
      if (!hold || $urandom_range(0, 3) == 0) rndSlots();
      dhStall = $urandom_range(0, 7) == 0;
      exStall = $urandom_range(0, 7) == 0;
      flush   = $urandom_range(0, 11) == 0;
      rst     = $urandom_range(0, 59) == 0;
      step("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
